// File: rtl/conv_window_buffer.sv
// conv_window_buffer: raster-order pixel stream to KxK sliding window.
// Holds K-1 previous lines and emits one window per valid-mode position.
module conv_window_buffer #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 5,
    parameter int IMG_WIDTH   = 28,
    parameter int IMG_HEIGHT  = 28
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        restart,
    input  logic [DATA_WIDTH-1:0]                       in_pixel,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    output logic [(KERNEL_SIZE**2)*DATA_WIDTH-1:0]      pixel_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        out_last,
    output logic                                        frame_done
);

    localparam int K  = KERNEL_SIZE;
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [DW-1:0]    r_line [K-1][IMG_WIDTH];
    logic [DW-1:0]    r_win [K][K];
    logic [DW-1:0]    w_win_next [K][K];
    logic [K*K*DW-1:0] w_flat;

    logic w_accept;
    logic w_xfer;
    logic w_col_end;
    logic w_frame_end;
    logic w_win_pos;

    // restart blocks intake so no pixel lands in a frame being abandoned
    assign in_ready    = !restart && (!out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_xfer      = out_valid && out_ready;
    assign w_col_end   = (r_col == COL_LAST);
    assign w_frame_end = w_col_end && (r_row == ROW_LAST);
    assign w_win_pos   = (r_row >= ROW_WIN) && (r_col >= COL_WIN);

    // window after shifting left and appending the new column;
    // line slot 0 holds row-1, slot K-2 holds row-K+1
    for (genvar gr = 0; gr < K; gr++) begin : g_row
        for (genvar gc = 0; gc < K; gc++) begin : g_col
            if (gc < K - 1) begin : g_shift
                assign w_win_next[gr][gc] = r_win[gr][gc+1];
            end else if (gr == K - 1) begin : g_new
                assign w_win_next[gr][gc] = in_pixel;
            end else begin : g_tap
                assign w_win_next[gr][gc] = r_line[K-2-gr][r_col];
            end
            assign w_flat[(gr*K+gc)*DW +: DW] = w_win_next[gr][gc];
        end
    end

    // line storage: read-before-write at col, lines age down one slot
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line[0][r_col] <= in_pixel;
            for (int j = 1; j < K - 1; j++) begin
                r_line[j][r_col] <= r_line[j-1][r_col];
            end
        end
    end

    // raster position of the next pixel to be accepted
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // window shift register; stale columns after a line wrap are never emitted
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            r_win <= w_win_next;
        end
    end

    // output register: new window replaces the old one with no bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_data <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else if (restart) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_accept && w_frame_end;
            if (w_accept && w_win_pos) begin
                pixel_data <= w_flat;
                out_valid  <= 1'b1;
                out_last   <= w_frame_end;
            end else if (w_xfer) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_buffer.sv
// tb_conv_window_buffer: scenario tasks against a frame-image reference
// model that cuts each expected window straight out of the stored image.
module tb_conv_window_buffer;

    localparam int DW = 16;
    localparam int K  = 5;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int PW = K * K * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          restart = 1'b0;
    logic [DW-1:0] in_pixel = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] pixel_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          frame_done;

    always #5 clk = ~clk;

    conv_window_buffer #(
        .DATA_WIDTH (DW),
        .KERNEL_SIZE(K),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pixel_data(pixel_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_done(frame_done)
    );

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [PW-1:0] d;
        logic          l;
    } win_t;

    logic [DW-1:0] img [H][W];
    int            mrow = 0;
    int            mcol = 0;
    win_t          exp_q[$];
    logic          fd_pend = 1'b0;

    logic          s_ov, s_ol, s_ir, s_fd, s_acc;
    logic [PW-1:0] s_od;
    logic          e_ov, e_ol, e_ir, e_fd;
    logic [PW-1:0] e_od;

    function automatic logic [PW-1:0] ref_window(input int row, input int col);
        logic [PW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[(r*K+c)*DW +: DW] = img[row-K+1+r][col-K+1+c];
        return w;
    endfunction

    function automatic logic [DW-1:0] el(input logic [PW-1:0] w, input int i);
        return w[i*DW +: DW];
    endfunction

    // one clock: drive inputs, sample outputs, advance the reference model
    task automatic drive(input logic v, input logic [DW-1:0] pix,
                         input logic ordy, input logic rs, input logic rst);
        logic acc;
        logic last;
        win_t w;
        @(negedge clk);
        in_valid  = v;
        in_pixel  = pix;
        out_ready = ordy;
        restart   = rs;
        reset     = rst;
        #1;
        s_ov = out_valid;
        s_ol = out_last;
        s_od = pixel_data;
        s_ir = in_ready;
        s_fd = frame_done;
        e_ov = (exp_q.size() != 0);
        e_od = e_ov ? exp_q[0].d : '0;
        e_ol = e_ov ? exp_q[0].l : 1'b0;
        e_ir = !rs && (!e_ov || ordy);
        e_fd = fd_pend;
        acc = v && e_ir && !rst;
        fd_pend = 1'b0;
        if (rst || rs) begin
            exp_q.delete();
            mrow = 0;
            mcol = 0;
            acc = 1'b0;
        end else begin
            if (e_ov && ordy) void'(exp_q.pop_front());
            if (acc) begin
                img[mrow][mcol] = pix;
                last = (mrow == H - 1) && (mcol == W - 1);
                if (mrow >= K - 1 && mcol >= K - 1) begin
                    w.d = ref_window(mrow, mcol);
                    w.l = last;
                    exp_q.push_back(w);
                end
                fd_pend = last;
                mcol = mcol + 1;
                if (mcol == W) begin
                    mcol = 0;
                    mrow = (mrow + 1) % H;
                end
            end
        end
        s_acc = acc;
        @(posedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        n_chk++;
        if ({s_ov, s_ol, s_fd} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got v/l/fd=%b%b%b, want 000", s_ov, s_ol, s_fd);
        end
        n_chk++;
        if (s_od !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, want 0", s_od);
        end
        n_chk++;
        if (s_ir !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, want 1", s_ir);
        end
    endtask

    task automatic test_basic_stream();
        int p = 0;
        int nwin = 0;
        int nfd = 0;
        bit first = 1'b1;
        for (int cyc = 0; cyc < W * H + 3; cyc++) begin
            drive(p < W * H, DW'(p), 1'b1, 1'b0, 1'b0);
            n_chk++;
            if (s_ov !== e_ov || (e_ov && {s_ol, s_od} !== {e_ol, e_od})) begin
                n_fail++;
                $display("FAIL basic_win: got v=%b l=%b d=%h, want v=%b l=%b d=%h",
                         s_ov, s_ol, s_od, e_ov, e_ol, e_od);
            end
            n_chk++;
            if (s_fd !== e_fd || s_ir !== e_ir) begin
                n_fail++;
                $display("FAIL basic_hs: got fd=%b rdy=%b, want fd=%b rdy=%b",
                         s_fd, s_ir, e_fd, e_ir);
            end
            if (s_fd === 1'b1) nfd++;
            if (s_ov === 1'b1) begin
                nwin++;
                n_chk++;
                if (el(s_od, 24) % 8 < 4) begin
                    n_fail++;
                    $display("FAIL basic_nocol: got window at pixel %0d, want col>=4",
                             el(s_od, 24));
                end
                if (first) begin
                    first = 1'b0;
                    n_chk++;
                    if (p != 37) begin
                        n_fail++;
                        $display("FAIL basic_latency: got first window after %0d pixels, want 37", p);
                    end
                    n_chk++;
                    if ({el(s_od, 0), el(s_od, 4), el(s_od, 20), el(s_od, 24)} !==
                        {16'd0, 16'd4, 16'd32, 16'd36}) begin
                        n_fail++;
                        $display("FAIL basic_first: got %0d %0d %0d %0d, want 0 4 32 36",
                                 el(s_od, 0), el(s_od, 4), el(s_od, 20), el(s_od, 24));
                    end
                end
                if (el(s_od, 24) == 16'd44) begin
                    n_chk++;
                    if (el(s_od, 0) !== 16'd8) begin
                        n_fail++;
                        $display("FAIL line_wrap: got e0=%0d, want 8", el(s_od, 0));
                    end
                end
                if (s_ol === 1'b1) begin
                    n_chk++;
                    if ({el(s_od, 0), el(s_od, 24)} !== {16'd27, 16'd63}) begin
                        n_fail++;
                        $display("FAIL basic_last: got e0=%0d e24=%0d, want 27 63",
                                 el(s_od, 0), el(s_od, 24));
                    end
                end
            end
            if (s_acc) p++;
        end
        n_chk++;
        if (nwin != 16 || nfd != 1 || p != W * H) begin
            n_fail++;
            $display("FAIL basic_count: got win=%0d fd=%0d pix=%0d, want 16 1 64", nwin, nfd, p);
        end
    endtask

    task automatic test_backpressure();
        int p = 0;
        int nwin = 0;
        int stall = 0;
        bit stalled = 1'b0;
        logic ordy;
        for (int cyc = 0; cyc < W * H + 20; cyc++) begin
            if (!stalled && exp_q.size() != 0) begin
                stalled = 1'b1;
                stall = 5;
            end
            ordy = (stall == 0);
            drive(p < W * H, DW'(p), ordy, 1'b0, 1'b0);
            n_chk++;
            if (s_ov !== e_ov || (e_ov && {s_ol, s_od} !== {e_ol, e_od})) begin
                n_fail++;
                $display("FAIL bp_win: got v=%b l=%b d=%h, want v=%b l=%b d=%h",
                         s_ov, s_ol, s_od, e_ov, e_ol, e_od);
            end
            n_chk++;
            if (s_fd !== e_fd || s_ir !== e_ir) begin
                n_fail++;
                $display("FAIL bp_hs: got fd=%b rdy=%b, want fd=%b rdy=%b",
                         s_fd, s_ir, e_fd, e_ir);
            end
            if (stall > 0) begin
                n_chk++;
                if (s_ir !== 1'b0 || el(s_od, 24) !== 16'd36) begin
                    n_fail++;
                    $display("FAIL bp_hold: got rdy=%b e24=%0d, want rdy=0 e24=36",
                             s_ir, el(s_od, 24));
                end
                stall--;
            end
            if (s_ov === 1'b1 && ordy) begin
                if (nwin == 1) begin
                    n_chk++;
                    if (el(s_od, 24) !== 16'd37) begin
                        n_fail++;
                        $display("FAIL bp_next: got e24=%0d, want 37", el(s_od, 24));
                    end
                end
                nwin++;
            end
            if (s_acc) p++;
        end
        n_chk++;
        if (nwin != 16 || p != W * H) begin
            n_fail++;
            $display("FAIL bp_count: got win=%0d pix=%0d, want 16 64", nwin, p);
        end
    endtask

    task automatic test_back_to_back();
        int p = 0;
        int nfd = 0;
        bit first2 = 1'b1;
        bit clean;
        for (int cyc = 0; cyc < 2 * W * H + 3; cyc++) begin
            drive(p < 2 * W * H, DW'((p % 64) + 100 * (p / 64)), 1'b1, 1'b0, 1'b0);
            n_chk++;
            if (s_ov !== e_ov || (e_ov && {s_ol, s_od} !== {e_ol, e_od})) begin
                n_fail++;
                $display("FAIL b2b_win: got v=%b l=%b d=%h, want v=%b l=%b d=%h",
                         s_ov, s_ol, s_od, e_ov, e_ol, e_od);
            end
            n_chk++;
            if (s_fd !== e_fd || s_ir !== e_ir) begin
                n_fail++;
                $display("FAIL b2b_hs: got fd=%b rdy=%b, want fd=%b rdy=%b",
                         s_fd, s_ir, e_fd, e_ir);
            end
            if (s_fd === 1'b1) nfd++;
            if (s_ov === 1'b1 && p > W * H) begin
                clean = 1'b1;
                for (int i = 0; i < K * K; i++)
                    if (el(s_od, i) < 16'd100) clean = 1'b0;
                n_chk++;
                if (!clean) begin
                    n_fail++;
                    $display("FAIL b2b_stale: got frame-1 data in %h", s_od);
                end
                if (first2) begin
                    first2 = 1'b0;
                    n_chk++;
                    if (el(s_od, 0) !== 16'd100) begin
                        n_fail++;
                        $display("FAIL b2b_first: got e0=%0d, want 100", el(s_od, 0));
                    end
                end
            end
            if (s_acc) p++;
        end
        n_chk++;
        if (nfd != 2 || p != 2 * W * H) begin
            n_fail++;
            $display("FAIL b2b_count: got fd=%0d pix=%0d, want 2 128", nfd, p);
        end
    endtask

    // stream one full frame from (0,0) and check the first window timing
    task automatic frame_after_break(input string tag, input logic [DW-1:0] base);
        int p = 0;
        bit first = 1'b1;
        for (int cyc = 0; cyc < W * H + 3; cyc++) begin
            drive(p < W * H, DW'(p) + base, 1'b1, 1'b0, 1'b0);
            n_chk++;
            if (s_ov !== e_ov || (e_ov && {s_ol, s_od} !== {e_ol, e_od})) begin
                n_fail++;
                $display("FAIL %s_win: got v=%b l=%b d=%h, want v=%b l=%b d=%h",
                         tag, s_ov, s_ol, s_od, e_ov, e_ol, e_od);
            end
            if (s_ov === 1'b1 && first) begin
                first = 1'b0;
                n_chk++;
                if (p != 37 || el(s_od, 0) !== base) begin
                    n_fail++;
                    $display("FAIL %s_first: got pix=%0d e0=%0d, want 37 %0d",
                             tag, p, el(s_od, 0), base);
                end
            end
            if (s_acc) p++;
        end
        n_chk++;
        if (p != W * H || first) begin
            n_fail++;
            $display("FAIL %s_count: got pix=%0d seen=%b, want 64 1", tag, p, !first);
        end
    endtask

    task automatic test_mid_reset();
        for (int p = 0; p < 28; p++) drive(1'b1, DW'(p + 500), 1'b1, 1'b0, 1'b0);
        drive(1'b1, 16'd999, 1'b1, 1'b0, 1'b1);
        n_chk++;
        if (s_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got valid=%b, want 0", s_ov);
        end
        frame_after_break("rst", 16'd0);
    endtask

    task automatic test_restart();
        for (int cyc = 0; cyc < 38; cyc++) begin
            drive(1'b1, DW'(cyc + 300), 1'b0, 1'b0, 1'b0);
            n_chk++;
            if (s_ov !== e_ov || s_ir !== e_ir) begin
                n_fail++;
                $display("FAIL rs_fill: got v=%b rdy=%b, want v=%b rdy=%b",
                         s_ov, s_ir, e_ov, e_ir);
            end
        end
        drive(1'b1, 16'd777, 1'b0, 1'b1, 1'b0);
        n_chk++;
        if (s_ir !== 1'b0 || s_ov !== 1'b1) begin
            n_fail++;
            $display("FAIL rs_during: got rdy=%b v=%b, want rdy=0 v=1", s_ir, s_ov);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if ({s_ov, s_ol, s_ir} !== 3'b001) begin
            n_fail++;
            $display("FAIL rs_after: got v/l/rdy=%b%b%b, want 001", s_ov, s_ol, s_ir);
        end
        frame_after_break("rs", 16'd0);
    endtask

    task automatic test_random();
        int p = 0;
        int nwin = 0;
        int tail = 0;
        logic ordy;
        for (int cyc = 0; cyc < 3000 && tail < 4; cyc++) begin
            ordy = (p >= 3 * W * H) || ($urandom_range(0, 9) < 7);
            drive((p < 3 * W * H) && ($urandom_range(0, 3) != 0),
                  DW'($urandom), ordy, 1'b0, 1'b0);
            n_chk++;
            if (s_ov !== e_ov || (e_ov && {s_ol, s_od} !== {e_ol, e_od})) begin
                n_fail++;
                $display("FAIL rand_win: got v=%b l=%b d=%h, want v=%b l=%b d=%h",
                         s_ov, s_ol, s_od, e_ov, e_ol, e_od);
            end
            n_chk++;
            if (s_fd !== e_fd || s_ir !== e_ir) begin
                n_fail++;
                $display("FAIL rand_hs: got fd=%b rdy=%b, want fd=%b rdy=%b",
                         s_fd, s_ir, e_fd, e_ir);
            end
            if (s_ov === 1'b1 && ordy) nwin++;
            if (s_acc) p++;
            if (p >= 3 * W * H) tail++;
        end
        n_chk++;
        if (p != 3 * W * H || nwin != 48) begin
            n_fail++;
            $display("FAIL rand_count: got pix=%0d win=%0d, want 192 48", p, nwin);
        end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_restart();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
